// File: rtl/booth_pp_reduce_64.sv
// booth_pp_reduce_64
//
// Reduction stage behind the radix-4 Booth partial-product generator of the
// 32x32 multiplier. It sums the 17 signed 34-bit partial products with a
// carry-save tree and a final carry-propagate adder. The result is a 64-bit
// product with a valid/ready handshake and a sideband tag.
//
// Pipeline (one result per cycle when not back-pressured):
//   S1 : capture, CSA levels 17(+1) rows -> 6 rows
//   S2 : CSA levels 6 rows -> sum/carry pair
//   S3 : 64-bit carry-propagate add, drives o_product/o_tag
//
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready      input handshake for one partial-product set
//   i_pp1 .. i_pp17        34-bit two's complement partial products,
//                          i_ppK carries weight 4^(K-1)
//   i_acc                  64-bit addend, only present with BOOTH_PP_ACC_EN
//   i_tag                  sideband tag, returned unchanged with the result
//   o_valid / i_ready      output handshake
//   o_product              sum of all rows, mod 2^64
//   o_tag                  tag belonging to o_product
//
// Configuration macro:
//   BOOTH_PP_ACC_EN        adds the i_acc port, which enters the tree as an
//                          extra row (multiply-accumulate use)

module booth_pp_reduce_64 #(
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [33:0]      i_pp1,
  input  logic [33:0]      i_pp2,
  input  logic [33:0]      i_pp3,
  input  logic [33:0]      i_pp4,
  input  logic [33:0]      i_pp5,
  input  logic [33:0]      i_pp6,
  input  logic [33:0]      i_pp7,
  input  logic [33:0]      i_pp8,
  input  logic [33:0]      i_pp9,
  input  logic [33:0]      i_pp10,
  input  logic [33:0]      i_pp11,
  input  logic [33:0]      i_pp12,
  input  logic [33:0]      i_pp13,
  input  logic [33:0]      i_pp14,
  input  logic [33:0]      i_pp15,
  input  logic [33:0]      i_pp16,
  input  logic [33:0]      i_pp17,
`ifdef BOOTH_PP_ACC_EN
  input  logic [63:0]      i_acc,
`endif
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_product,
  output logic [TAG_W-1:0] o_tag
);

  // Rows left after one level of 3:2 compressors.
  function automatic int csa_rows(input int n);
    return (n / 3) * 2 + n % 3;
  endfunction

  // Each partial product enters the tree with its sign bit inverted, which
  // adds 2^(33+2k) to row k. Summing the negated offsets once gives a single
  // constant row that replaces full sign replication. Offsets at or beyond
  // bit 64 vanish modulo 2^64.
  function automatic logic [63:0] sign_comp_const();
    logic [63:0] c;
    c = '0;
    for (int k = 0; k < 17; k++) c = c - (64'd1 << (33 + 2 * k));
    return c;
  endfunction

  // 3:2 compressor on full 64-bit rows, returns {carry, sum}.
  function automatic logic [127:0] csa(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c);
    logic [63:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {maj[62:0], 1'b0, a ^ b ^ c};
  endfunction

`ifdef BOOTH_PP_ACC_EN
  localparam int N_ROWS = 19;
`else
  localparam int N_ROWS = 18;
`endif
  localparam int L1 = csa_rows(N_ROWS);
  localparam int L2 = csa_rows(L1);
  localparam int L3 = csa_rows(L2);
  localparam int M1 = csa_rows(L3);
  localparam int M2 = csa_rows(M1);
  localparam int M3 = csa_rows(M2);
  localparam logic [63:0] SIGN_COMP = sign_comp_const();

  logic [33:0]      pp [17];
  logic [63:0]      r0 [N_ROWS];
  logic [63:0]      r1 [L1];
  logic [63:0]      r2 [L2];
  logic [63:0]      r3 [L3];
  logic [63:0]      s1_row [L3];
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic [63:0]      t1 [M1];
  logic [63:0]      t2 [M2];
  logic [63:0]      t3 [M3];
  logic [63:0]      s2_sum;
  logic [63:0]      s2_carry;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_valid;
  logic             take1;
  logic             take2;
  logic             take3;

  assign pp[0]  = i_pp1;
  assign pp[1]  = i_pp2;
  assign pp[2]  = i_pp3;
  assign pp[3]  = i_pp4;
  assign pp[4]  = i_pp5;
  assign pp[5]  = i_pp6;
  assign pp[6]  = i_pp7;
  assign pp[7]  = i_pp8;
  assign pp[8]  = i_pp9;
  assign pp[9]  = i_pp10;
  assign pp[10] = i_pp11;
  assign pp[11] = i_pp12;
  assign pp[12] = i_pp13;
  assign pp[13] = i_pp14;
  assign pp[14] = i_pp15;
  assign pp[15] = i_pp16;
  assign pp[16] = i_pp17;

  // A stage may load when it is empty or when the stage after it loads.
  // Stage 3 is the output register and drains on i_ready.
  assign take3   = ~o_valid | i_ready;
  assign take2   = ~s2_valid | take3;
  assign take1   = ~s1_valid | take2;
  assign o_ready = take1;

  // Initial rows: sign-inverted, weighted partial products plus the
  // compensation constant (and the accumulator when enabled).
  always_comb begin
    for (int k = 0; k < N_ROWS; k++) r0[k] = '0;
    for (int k = 0; k < 17; k++) r0[k] = 64'({~pp[k][33], pp[k][32:0]}) << (2 * k);
    r0[17] = SIGN_COMP;
`ifdef BOOTH_PP_ACC_EN
    r0[18] = i_acc;
`endif
  end

  // S1 tree: groups of three rows compress to two, leftovers pass through.
  always_comb begin
    for (int i = 0; i < L1; i++) r1[i] = '0;
    for (int g = 0; g < N_ROWS / 3; g++)
      {r1[2*g+1], r1[2*g]} = csa(r0[3*g], r0[3*g+1], r0[3*g+2]);
    for (int k = 0; k < N_ROWS % 3; k++)
      r1[2*(N_ROWS/3)+k] = r0[3*(N_ROWS/3)+k];
  end

  always_comb begin
    for (int i = 0; i < L2; i++) r2[i] = '0;
    for (int g = 0; g < L1 / 3; g++)
      {r2[2*g+1], r2[2*g]} = csa(r1[3*g], r1[3*g+1], r1[3*g+2]);
    for (int k = 0; k < L1 % 3; k++)
      r2[2*(L1/3)+k] = r1[3*(L1/3)+k];
  end

  always_comb begin
    for (int i = 0; i < L3; i++) r3[i] = '0;
    for (int g = 0; g < L2 / 3; g++)
      {r3[2*g+1], r3[2*g]} = csa(r2[3*g], r2[3*g+1], r2[3*g+2]);
    for (int k = 0; k < L2 % 3; k++)
      r3[2*(L2/3)+k] = r2[3*(L2/3)+k];
  end

  // S2 tree: six registered rows down to a sum/carry pair.
  always_comb begin
    for (int i = 0; i < M1; i++) t1[i] = '0;
    for (int g = 0; g < L3 / 3; g++)
      {t1[2*g+1], t1[2*g]} = csa(s1_row[3*g], s1_row[3*g+1], s1_row[3*g+2]);
    for (int k = 0; k < L3 % 3; k++)
      t1[2*(L3/3)+k] = s1_row[3*(L3/3)+k];
  end

  always_comb begin
    for (int i = 0; i < M2; i++) t2[i] = '0;
    for (int g = 0; g < M1 / 3; g++)
      {t2[2*g+1], t2[2*g]} = csa(t1[3*g], t1[3*g+1], t1[3*g+2]);
    for (int k = 0; k < M1 % 3; k++)
      t2[2*(M1/3)+k] = t1[3*(M1/3)+k];
  end

  always_comb begin
    for (int i = 0; i < M3; i++) t3[i] = '0;
    for (int g = 0; g < M2 / 3; g++)
      {t3[2*g+1], t3[2*g]} = csa(t2[3*g], t2[3*g+1], t2[3*g+2]);
    for (int k = 0; k < M2 % 3; k++)
      t3[2*(M2/3)+k] = t2[3*(M2/3)+k];
  end

  // Valid bits and the output register carry reset; the output register
  // holds its value whenever o_valid is set and i_ready is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      o_valid   <= 1'b0;
      o_product <= '0;
      o_tag     <= '0;
    end else begin
      if (take1) s1_valid <= i_valid;
      if (take2) s2_valid <= s1_valid;
      if (take3) begin
        o_valid <= s2_valid;
        if (s2_valid) begin
          o_product <= s2_sum + s2_carry;
          o_tag     <= s2_tag;
        end
      end
    end
  end

  // Intermediate data registers only load with a valid set; contents of
  // empty stages are don't-care.
  always_ff @(posedge i_clk) begin
    if (take1 && i_valid) begin
      for (int i = 0; i < L3; i++) s1_row[i] <= r3[i];
      s1_tag <= i_tag;
    end
    if (take2 && s1_valid) begin
      s2_sum   <= t3[0];
      s2_carry <= t3[1];
      s2_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_booth_pp_reduce_64.sv
// Self-checking bench for booth_pp_reduce_64. Partial products come from a
// Booth encoder model in the bench; expected products come from direct
// multiplication of the operands, queued on acceptance and compared on output.

module tb_booth_pp_reduce_64;

  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0]      product;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [33:0]      pp_drv [17];
  logic [TAG_W-1:0] tag_drv = '0;
`ifdef BOOTH_PP_ACC_EN
  logic [63:0]      acc_drv = '0;
`endif
  logic             o_ready;
  logic             o_valid;
  logic [63:0]      o_product;
  logic [TAG_W-1:0] o_tag;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  int          pops_base;
  logic [577:0] pv;
  logic [577:0] bp_pv [5];
  logic [63:0]  bp_exp [5];
  logic [31:0]  a;
  logic [31:0]  b;
  bit           sa;
  bit           sbs;

  booth_pp_reduce_64 #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_pp1(pp_drv[0]), .i_pp2(pp_drv[1]), .i_pp3(pp_drv[2]), .i_pp4(pp_drv[3]),
    .i_pp5(pp_drv[4]), .i_pp6(pp_drv[5]), .i_pp7(pp_drv[6]), .i_pp8(pp_drv[7]),
    .i_pp9(pp_drv[8]), .i_pp10(pp_drv[9]), .i_pp11(pp_drv[10]), .i_pp12(pp_drv[11]),
    .i_pp13(pp_drv[12]), .i_pp14(pp_drv[13]), .i_pp15(pp_drv[14]), .i_pp16(pp_drv[15]),
    .i_pp17(pp_drv[16]),
`ifdef BOOTH_PP_ACC_EN
    .i_acc(acc_drv),
`endif
    .i_tag(tag_drv), .o_valid(o_valid), .i_ready(i_ready),
    .o_product(o_product), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Radix-4 Booth encoding of a*b into 17 34-bit partial products, packed.
  function automatic logic [577:0] boothEncode(input logic [31:0] av_in, input logic [31:0] bv_in,
                                               input bit a_sgn, input bit b_sgn);
    logic [577:0] v;
    longint       av;
    longint       prod;
    logic [34:0]  bx;
    logic [2:0]   trip;
    int           d;
    v  = '0;
    av = a_sgn ? longint'($signed(av_in)) : longint'({32'b0, av_in});
    bx = {(b_sgn ? {2{bv_in[31]}} : 2'b00), bv_in, 1'b0};
    for (int i = 0; i < 17; i++) begin
      trip = bx[2*i+2 -: 3];
      case (trip)
        3'b001, 3'b010: d = 1;
        3'b011:         d = 2;
        3'b100:         d = -2;
        3'b101, 3'b110: d = -1;
        default:        d = 0;
      endcase
      prod = av * longint'(d);
      v[i*34 +: 34] = prod[33:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] refProduct(input logic [31:0] av_in, input logic [31:0] bv_in,
                                             input bit a_sgn, input bit b_sgn);
    longint av;
    longint bv;
    av = a_sgn ? longint'($signed(av_in)) : longint'({32'b0, av_in});
    bv = b_sgn ? longint'($signed(bv_in)) : longint'({32'b0, bv_in});
    return av * bv;
  endfunction

  // Drives one set and waits (bounded) for it to be accepted; returns 1ns
  // after the accepting edge with i_valid still high.
  task automatic applyStimulus(input logic [577:0] p, input logic [TAG_W-1:0] tag,
                               input logic [63:0] expected);
    int n;
    bit accepted;
    for (int k = 0; k < 17; k++) pp_drv[k] = p[k*34 +: 34];
    tag_drv  = tag;
    i_valid  = 1'b1;
    n        = 0;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (o_ready) begin
        accepted = 1'b1;
        sb.push_back('{expected, tag});
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every transfer out is compared with the oldest queued
  // expectation, product and tag together.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checkOutput("out_without_accept", 64'(o_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("product", o_product, e.product);
        checkOutput("tag", 64'(o_tag), 64'(e.tag));
      end
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 17; k++) pp_drv[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_o_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_o_product", o_product, 64'd0);
    checkOutput("rst_o_tag", 64'(o_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_o_ready", 64'(o_ready), 64'd1);

    // 3*5 with fixed latency check.
    $display("[TB] directed 3*5");
    pv = '0;
    pv[0 +: 34]  = 34'd3;
    pv[34 +: 34] = 34'd3;
    applyStimulus(pv, 4'd1, 64'h0F);
    i_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_cycle1", 64'(o_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_cycle2", 64'(o_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_cycle3", 64'(o_valid), 64'd1);
    waitDrain();

    // Sign handling of a lone partial product.
    $display("[TB] directed sign cases");
    pv = '0;
    pv[0 +: 34] = 34'h1;
    applyStimulus(pv, 4'd2, 64'h1);
    pv[0 +: 34] = 34'h3FFFFFFFF;
    applyStimulus(pv, 4'd3, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(boothEncode(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0), 4'd4,
                  64'hFFFFFFFE00000001);
    applyStimulus(boothEncode(32'h80000000, 32'h80000000, 1'b1, 1'b1), 4'd5,
                  64'h4000000000000000);
    applyStimulus(boothEncode(32'hFFFFFFFF, 32'd7, 1'b1, 1'b0), 4'd6,
                  64'hFFFFFFFFFFFFFFF9);
    i_valid = 1'b0;
    waitDrain();

    // Back-to-back random sweep, one result per cycle.
    $display("[TB] random sweep");
    first_pop = -1;
    pops_base = pops;
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom;
      b   = $urandom;
      sa  = 1'($urandom_range(0, 1));
      sbs = 1'($urandom_range(0, 1));
      applyStimulus(boothEncode(a, b, sa, sbs), 4'(i), refProduct(a, b, sa, sbs));
    end
    i_valid = 1'b0;
    waitDrain();
    checkOutput("sweep_count", 64'(pops - pops_base), 64'd1000);
    checkOutput("sweep_rate", 64'(last_pop - first_pop), 64'd999);

    // Backpressure: three sets fill the pipe, the fourth waits.
    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      a   = $urandom;
      b   = $urandom;
      sa  = 1'(i & 1);
      sbs = 1'((i >> 1) & 1);
      bp_pv[i]  = boothEncode(a, b, sa, sbs);
      bp_exp[i] = refProduct(a, b, sa, sbs);
    end
    pops_base = pops;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(bp_pv[i], 4'(8 + i), bp_exp[i]);
    fork
      applyStimulus(bp_pv[3], 4'd11, bp_exp[3]);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("bp_o_ready", 64'(o_ready), 64'd0);
          checkOutput("bp_o_valid", 64'(o_valid), 64'd1);
          checkOutput("bp_hold_product", o_product, bp_exp[0]);
        end
        checkOutput("bp_accepted", 64'(sb.size()), 64'd3);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    applyStimulus(bp_pv[4], 4'd12, bp_exp[4]);
    i_valid = 1'b0;
    waitDrain();
    checkOutput("bp_count", 64'(pops - pops_base), 64'd5);

    // Reset while two sets are in flight.
    $display("[TB] reset mid-flight");
    pops_base = pops;
    applyStimulus(bp_pv[0], 4'd13, bp_exp[0]);
    applyStimulus(bp_pv[1], 4'd14, bp_exp[1]);
    i_valid = 1'b0;
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_o_valid", 64'(o_valid), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_o_valid", 64'(o_valid), 64'd0);
      checkOutput("post_rst_o_ready", 64'(o_ready), 64'd1);
    end
    checkOutput("post_rst_count", 64'(pops - pops_base), 64'd0);
    @(posedge clk);
    #1;
    pv = '0;
    pv[0 +: 34]  = 34'd3;
    pv[34 +: 34] = 34'd3;
    applyStimulus(pv, 4'd15, 64'h0F);
    i_valid = 1'b0;
    waitDrain();

`ifdef BOOTH_PP_ACC_EN
    $display("[TB] accumulate");
    acc_drv = 64'h100;
    applyStimulus(pv, 4'd7, 64'h10F);
    i_valid = 1'b0;
    waitDrain();
    acc_drv = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
